hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/config.vh | 11 +
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Hazard controller types: FSM states and pipeline control bundle.
// Encodings come from config.vh so software and RTL agree.
`include "config.vh"

package hazard_ctrl_pkg;

    typedef enum logic [`HC_ST_W-1:0] {
        ST_RUN   = `HC_ST_RUN,
        ST_FLUSH = `HC_ST_FLUSH,
        ST_HALT  = `HC_ST_HALT
    } hc_state_e;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic ex_stall;
        logic id_clr;
        logic ex_clr;
    } hc_ctrl_t;

    // Nothing moves, nothing cleared.
    localparam hc_ctrl_t CTRL_NONE   = hc_ctrl_t'(5'b00000);
    // Whole pipe frozen.
    localparam hc_ctrl_t CTRL_FREEZE = hc_ctrl_t'(5'b11100);
    // Wrong-path instructions in ID and ID/EX squashed.
    localparam hc_ctrl_t CTRL_FLUSH  = hc_ctrl_t'(5'b00011);
    // Front end held, one bubble into EX.
    localparam hc_ctrl_t CTRL_BUBBLE = hc_ctrl_t'(5'b11001);

    // Flush cycles still owed after the branch cycle itself.
    function automatic logic [2:0] flush_load(input int len);
        return 3'(len - 1);
    endfunction

endpackage

// File: rtl/config.vh
// Shared encodings for the hazard controller state.
// Guarded so several files can pull it in.
`ifndef HC_CONFIG_VH
`define HC_CONFIG_VH

`define HC_ST_W     2
`define HC_ST_RUN   2'd0
`define HC_ST_FLUSH 2'd1
`define HC_ST_HALT  2'd2

`endif

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up, hold at all-ones, clear on request.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, halt and watchdog.
// Control outputs are Mealy; state and counters are registered.
`include "config.vh"

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_LEN = 1,
    parameter int MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                i_mem_hazard,
    input  logic                i_branch_taken,
    input  logic                i_dmem_busy,
    input  logic                i_halt,
    input  logic                i_resume,
    input  logic                i_cnt_clr,
    output logic                o_if_stall,
    output logic                o_id_stall,
    output logic                o_ex_stall,
    output logic                o_id_clr,
    output logic                o_ex_clr,
    output logic [`HC_ST_W-1:0] o_state,
    output logic [CNT_W-1:0]    o_stall_cnt,
    output logic [CNT_W-1:0]    o_flush_cnt,
    output logic                o_watchdog
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam hc_state_e BR_NEXT =
        (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;

    hc_state_e        state_q;
    logic [2:0]       fcnt_q;
    logic [RUN_W-1:0] run_q;
    logic             wd_q;
    hc_ctrl_t         ctrl;
    logic             br_take;
    logic             lu_stall;
    logic             stall_inc;

    assign br_take  = (state_q == ST_RUN) && !i_dmem_busy
                      && i_branch_taken;
    assign lu_stall = (state_q == ST_RUN) && !i_dmem_busy
                      && !i_branch_taken && i_mem_hazard;

    // Decode control bundle from state and the prioritised inputs.
    always_comb begin
        ctrl = CTRL_NONE;
        unique case (state_q)
            ST_RUN: begin
                if (i_dmem_busy)         ctrl = CTRL_FREEZE;
                else if (i_branch_taken) ctrl = CTRL_FLUSH;
                else if (i_mem_hazard)   ctrl = CTRL_BUBBLE;
                else                     ctrl = CTRL_NONE;
            end
            ST_FLUSH: ctrl = i_dmem_busy ? CTRL_FREEZE : CTRL_FLUSH;
            ST_HALT:  ctrl = CTRL_FREEZE;
            default:  ctrl = CTRL_NONE;
        endcase
    end

    assign o_if_stall = ctrl.if_stall;
    assign o_id_stall = ctrl.id_stall;
    assign o_ex_stall = ctrl.ex_stall;
    assign o_id_clr   = ctrl.id_clr;
    assign o_ex_clr   = ctrl.ex_clr;
    assign o_state    = state_q;
    assign o_watchdog = wd_q;

    // FSM: RUN / FLUSH / HALT with the remaining-flush counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (i_dmem_busy) begin
                        state_q <= ST_RUN;
                    end else if (i_branch_taken) begin
                        state_q <= BR_NEXT;
                        fcnt_q  <= flush_load(FLUSH_LEN);
                    end else if (i_mem_hazard) begin
                        state_q <= ST_RUN;
                    end else if (i_halt) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (!i_dmem_busy) begin
                        if (fcnt_q <= 3'd1) begin
                            fcnt_q  <= 3'd0;
                            state_q <= ST_RUN;
                        end else begin
                            fcnt_q <= fcnt_q - 3'd1;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_resume) state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                    fcnt_q  <= 3'd0;
                end
            endcase
        end
    end

    // Watchdog: run length of back-to-back load-use bubbles, sticky trip.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run_q <= '0;
            wd_q  <= 1'b0;
        end else begin
            if (!lu_stall)          run_q <= '0;
            else if (run_q < RUN_MAX) run_q <= run_q + 1'b1;
            if (run_q == RUN_MAX) wd_q <= 1'b1;
        end
    end

    assign stall_inc = ctrl.if_stall && (state_q != ST_HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (stall_inc),
        .clr     (i_cnt_clr),
        .q       (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (br_take),
        .clr     (i_cnt_clr),
        .q       (o_flush_cnt)
    );

endmodule
